gcd_job_sequencer: RTL

Front-end job sequencer for the GCD unit. It accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. It launches one job at a time on the GCD controller/datapath pair and returns each result over an output valid/ready stream. It sits directly upstream of the GCD controller: it drives that controller's `go_i` and the datapath operand inputs, and consumes `done` plus the datapath result register.

---
 rtl/gcd_job_sequencer_if.sv | 23 ++
 rtl/gcd_job_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/gcd_job_sequencer_if.sv
// Operand-pair input stream and result output stream of the GCD job sequencer.
interface gcd_job_sequencer_if #(
    parameter int unsigned W = 8
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x;
    logic [W-1:0] in_y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_d;
    logic         out_err;

    modport master (
        output in_valid, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_d, out_err
    );

    modport slave (
        input  in_valid, in_x, in_y, out_ready,
        output in_ready, out_valid, out_d, out_err
    );
endinterface

// File: rtl/gcd_job_sequencer.sv
// Buffers operand pairs in a FIFO, launches one job at a time on the GCD
// controller/datapath and returns each result (or error) on an output stream.
module gcd_job_sequencer #(
    parameter int unsigned W       = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    gcd_job_sequencer_if.slave   s,
    output logic                 go_o,
    output logic [W-1:0]         x_o,
    output logic [W-1:0]         y_o,
    input  logic                 done_i,
    input  logic [W-1:0]         d_i,
    output logic                 busy,
    output logic                 fault
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
    } pair_t;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_CLR,
        WAIT_DONE,
        RESULT
    } state_e;

    pair_t         mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    state_e        state_q, state_d;
    logic          go_q, go_d;
    logic [W-1:0]  x_q, x_d, y_q, y_d;
    logic          ov_q, ov_d;
    logic [W-1:0]  od_q, od_d;
    logic          oe_q, oe_d;
    logic          fault_q, fault_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          ph_q, ph_d;

    logic          push_c, pop_c;
    pair_t         head_c;

    assign s.in_ready = (count_q < CW'(DEPTH));
    assign push_c     = s.in_valid & s.in_ready;
    assign head_c     = mem_q[rd_ptr_q];

    // FIFO storage carries no reset: contents are meaningless once count is 0.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= '{x: s.in_x, y: s.in_y};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            go_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            oe_q    <= 1'b0;
            fault_q <= 1'b0;
            timer_q <= '0;
            ph_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            go_q    <= go_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            oe_q    <= oe_d;
            fault_q <= fault_d;
            timer_q <= timer_d;
            ph_q    <= ph_d;
        end
    end

    always_comb begin
        state_d = state_q;
        go_d    = 1'b0;
        x_d     = x_q;
        y_d     = y_q;
        ov_d    = ov_q & ~s.out_ready;
        od_d    = od_q;
        oe_d    = oe_q;
        fault_d = fault_q;
        timer_d = timer_q;
        ph_d    = ph_q;
        pop_c   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if ((count_q != '0) && !ov_q && !fault_q) begin
                    pop_c = 1'b1;
                    // A zero operand would never terminate in the controller.
                    if ((head_c.x == '0) || (head_c.y == '0)) begin
                        ov_d = 1'b1;
                        od_d = '0;
                        oe_d = 1'b1;
                    end else begin
                        x_d     = head_c.x;
                        y_d     = head_c.y;
                        ph_d    = 1'b0;
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                // Two go cycles so an alternate-cycle sampler always sees one.
                go_d = 1'b1;
                ph_d = 1'b1;
                if (ph_q) begin
                    timer_d = '0;
                    state_d = WAIT_CLR;
                end
            end
            WAIT_CLR, WAIT_DONE: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == TW'(TIMEOUT - 1)) begin
                    ov_d    = 1'b1;
                    od_d    = '0;
                    oe_d    = 1'b1;
                    fault_d = 1'b1;
                    state_d = IDLE;
                end else if ((state_q == WAIT_CLR) && !done_i) begin
                    state_d = WAIT_DONE;
                end else if ((state_q == WAIT_DONE) && done_i) begin
                    state_d = RESULT;
                end
            end
            RESULT: begin
                ov_d    = 1'b1;
                od_d    = d_i;
                oe_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign go_o        = go_q;
    assign x_o         = x_q;
    assign y_o         = y_q;
    assign s.out_valid = ov_q;
    assign s.out_d     = od_q;
    assign s.out_err   = oe_q;
    assign fault       = fault_q;
    assign busy        = (state_q != IDLE) | (count_q != '0) | ov_q;
endmodule
